// File: rtl/display_scan_ctrl_if.sv
// Control/data bundle between the display scan controller and its environment:
// scan controls and mux nibble in, hex-mux select and display drives out.
interface display_scan_ctrl_if;
  logic       enable;
  logic [3:0] hex_val;
  logic       lz_en;
  logic [3:0] blink_mask;
  logic       blink_tick;
  logic [3:0] dp_mask;
  logic [2:0] digit_sel;
  logic [3:0] anode_n;
  logic       dp_n;
  logic       frame_done;

  modport master (
    output enable, hex_val, lz_en, blink_mask, blink_tick, dp_mask,
    input  digit_sel, anode_n, dp_n, frame_done
  );

  modport slave (
    input  enable, hex_val, lz_en, blink_mask, blink_tick, dp_mask,
    output digit_sel, anode_n, dp_n, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: MSB-first digit multiplexing with a
// blanking guard per slot, leading-zero suppression and per-digit blinking.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  display_scan_ctrl_if.slave   bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_FIRST   = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    anode_q, anode_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;
  logic          phase_q, phase_d;
  logic          nz_q, nz_d;

  logic          nz_eff_s;
  logic          sup_lz_s;
  logic          sup_blink_s;
  logic          show_s;

  // Display decision for the digit currently selected; digit 3 starts a fresh frame.
  always_comb begin
    nz_eff_s    = (sel_q == 2'd3) ? 1'b0 : nz_q;
    sup_lz_s    = bus.lz_en && (bus.hex_val == 4'h0) && !nz_eff_s && (sel_q != 2'd0);
    sup_blink_s = phase_q && bus.blink_mask[sel_q];
    show_s      = !sup_lz_s && !sup_blink_s;
  end

  // Next-state logic for the scan sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    anode_d = anode_q;
    dp_d    = dp_q;
    fd_d    = 1'b0;
    nz_d    = nz_q;
    phase_d = phase_q ^ bus.blink_tick;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sel_d   = 2'd3;
      anode_d = 4'hF;
      dp_d    = 1'b1;
      nz_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
            cnt_d   = ON_FIRST;
            // Blanked digits still feed nonzero_seen so blink never alters lower digits.
            nz_d    = nz_eff_s || (bus.hex_val != 4'h0);
            if (show_s) begin
              anode_d = ~(4'b0001 << sel_q);
              dp_d    = ~bus.dp_mask[sel_q];
            end else begin
              anode_d = 4'hF;
              dp_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_ON: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            sel_d   = sel_q - 2'd1;
            anode_d = 4'hF;
            dp_d    = 1'b1;
            fd_d    = (sel_q == 2'd0);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sel_d   = 2'd3;
          anode_d = 4'hF;
          dp_d    = 1'b1;
          nz_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd3;
      anode_q <= 4'hF;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
      phase_q <= 1'b0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
      phase_q <= phase_d;
      nz_q    <= nz_d;
    end
  end

  assign bus.digit_sel  = {1'b0, sel_q};
  assign bus.anode_n    = anode_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a time-indexed scan model checked
// every cycle, plus hand-computed spot checks of the main scenarios.
module tb_display_scan_ctrl;

  localparam int R = 8;
  localparam int B = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] mux_val;
  int          n_tests;
  int          n_fail;
  int          tt;
  logic        chk_on;

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hex mux: combinational nibble select from digit_sel.
  logic [15:0] mux_shift;
  always_comb begin
    mux_shift   = mux_val >> {bus.digit_sel[1:0], 2'b00};
    bus.hex_val = mux_shift[3:0];
  end

  // Model state: running flag, cycles since scan start, latched slot decision.
  logic       m_run;
  int         m_t;
  logic       m_show;
  logic       m_dp;
  logic       m_phase;
  logic [3:0] m_nz;

  int         m_d;
  int         m_p;
  logic [3:0] m_nib;
  logic [15:0] m_shift;
  logic       m_above;
  logic       m_show_now;
  logic [2:0] exp_sel;
  logic [3:0] exp_an;
  logic       exp_dp;
  logic       exp_fd;

  // Model view of the current cycle derived from position within the frame.
  always_comb begin
    m_d     = 3 - ((m_t / R) % 4);
    m_p     = m_t % R;
    m_shift = mux_val >> (4 * m_d);
    m_nib   = m_shift[3:0];
    m_above = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > m_d && m_nz[j]) m_above = 1'b1;
    end
    m_show_now = !(bus.lz_en && m_nib == 4'h0 && !m_above && m_d != 0)
              && !(m_phase && bus.blink_mask[m_d]);
    exp_sel = m_run ? 3'(m_d) : 3'd3;
    if (m_run && m_p >= B && m_show) begin
      exp_an = ~(4'b0001 << m_d);
      exp_dp = m_dp;
    end else begin
      exp_an = 4'hF;
      exp_dp = 1'b1;
    end
    exp_fd = m_run && (m_t > 0) && (m_t % (4 * R) == 0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 1'b0; m_t <= 0; m_show <= 1'b0; m_dp <= 1'b1;
      m_phase <= 1'b0; m_nz <= 4'h0;
    end else begin
      if (bus.blink_tick) m_phase <= ~m_phase;
      if (!bus.enable) begin
        m_run <= 1'b0; m_t <= 0;
      end else if (!m_run) begin
        m_run <= 1'b1; m_t <= 0;
      end else begin
        m_t <= m_t + 1;
        if (m_p == B - 1) begin
          m_show <= m_show_now;
          m_dp   <= ~bus.dp_mask[m_d];
          if (m_d == 3) m_nz <= {(m_nib != 4'h0), 3'b000};
          else          m_nz[m_d] <= (m_nib != 4'h0);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("digit_sel", 32'(bus.digit_sel), 32'(exp_sel));
      check("anode_n", 32'(bus.anode_n), 32'(exp_an));
      check("dp_n", 32'(bus.dp_n), 32'(exp_dp));
      check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      check("one_anode", 32'($countones(~bus.anode_n) <= 1), 32'd1);
    end
  end

  task automatic adv(input int to);
    while (tt < to) begin
      @(negedge clk);
      tt++;
    end
  endtask

  task automatic start_scan();
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    tt = 0;
  endtask

  task automatic pulse_tick();
    bus.blink_tick = 1'b1;
    @(negedge clk);
    bus.blink_tick = 1'b0;
    tt++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; tt = 0; chk_on = 1'b0;
    reset_n = 1'b1;
    bus.enable = 1'b0; bus.lz_en = 1'b0; bus.blink_mask = 4'h0;
    bus.blink_tick = 1'b0; bus.dp_mask = 4'h0;
    mux_val = 16'h1234;
    #1 reset_n = 1'b0;
    #1;
    chk_on = 1'b1;
    check("rst_anode", 32'(bus.anode_n), 32'hF);
    check("rst_sel", 32'(bus.digit_sel), 32'd3);
    check("rst_dp", 32'(bus.dp_n), 32'd1);
    check("rst_fd", 32'(bus.frame_done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Plain scan of 1234
    start_scan();
    check("t1_blank", 32'(bus.anode_n), 32'hF);
    adv(2);  check("t1_d3", 32'(bus.anode_n), 32'h7); check("t1_sel3", 32'(bus.digit_sel), 32'd3);
    adv(10); check("t1_d2", 32'(bus.anode_n), 32'hB); check("t1_sel2", 32'(bus.digit_sel), 32'd2);
    adv(18); check("t1_d1", 32'(bus.anode_n), 32'hD);
    adv(26); check("t1_d0", 32'(bus.anode_n), 32'hE); check("t1_sel0", 32'(bus.digit_sel), 32'd0);
    adv(31); check("t1_fd_before", 32'(bus.frame_done), 32'd0);
    adv(32); check("t1_fd", 32'(bus.frame_done), 32'd1); check("t1_wrap_sel", 32'(bus.digit_sel), 32'd3);
    adv(33); check("t1_fd_after", 32'(bus.frame_done), 32'd0);

    // Leading-zero suppression
    bus.lz_en = 1'b1; mux_val = 16'h0050;
    start_scan();
    adv(2);  check("lz50_d3", 32'(bus.anode_n), 32'hF);
    adv(18); check("lz50_d1", 32'(bus.anode_n), 32'hD);
    adv(26); check("lz50_d0", 32'(bus.anode_n), 32'hE);
    mux_val = 16'h0000;
    start_scan();
    adv(18); check("lz00_d1", 32'(bus.anode_n), 32'hF);
    adv(26); check("lz00_d0", 32'(bus.anode_n), 32'hE);
    mux_val = 16'h0500;
    start_scan();
    adv(2);  check("lz500_d3", 32'(bus.anode_n), 32'hF);
    adv(10); check("lz500_d2", 32'(bus.anode_n), 32'hB);
    adv(18); check("lz500_d1", 32'(bus.anode_n), 32'hD);

    // Blink on digit 2
    bus.lz_en = 1'b0; mux_val = 16'h1234; bus.blink_mask = 4'b0100;
    start_scan();
    pulse_tick();
    adv(2);  check("bl_d3", 32'(bus.anode_n), 32'h7);
    adv(10); check("bl_d2_dark", 32'(bus.anode_n), 32'hF);
    adv(18); check("bl_d1", 32'(bus.anode_n), 32'hD);
    pulse_tick();
    adv(42); check("bl_d2_back", 32'(bus.anode_n), 32'hB);
    bus.lz_en = 1'b1; mux_val = 16'h0100;
    start_scan();
    pulse_tick();
    adv(10); check("bllz_d2", 32'(bus.anode_n), 32'hF);
    adv(18); check("bllz_d1", 32'(bus.anode_n), 32'hD);
    adv(26); check("bllz_d0", 32'(bus.anode_n), 32'hE);
    bus.blink_mask = 4'h0; bus.lz_en = 1'b0; mux_val = 16'h1234;

    // Decimal point on digit 2
    bus.dp_mask = 4'b0100;
    start_scan();
    adv(8);  check("dp_blank", 32'(bus.dp_n), 32'd1);
    adv(10); check("dp_on", 32'(bus.dp_n), 32'd0); check("dp_an", 32'(bus.anode_n), 32'hB);
    adv(18); check("dp_d1", 32'(bus.dp_n), 32'd1);
    bus.dp_mask = 4'h0;

    // Enable drop mid-ON of digit 1 and resume
    start_scan();
    adv(20);
    bus.enable = 1'b0;
    @(negedge clk);
    check("en_off_an", 32'(bus.anode_n), 32'hF);
    check("en_off_sel", 32'(bus.digit_sel), 32'd3);
    check("en_off_fd", 32'(bus.frame_done), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    tt = 0;
    check("en_on_sel", 32'(bus.digit_sel), 32'd3);
    check("en_on_an", 32'(bus.anode_n), 32'hF);
    adv(2);  check("en_on_d3", 32'(bus.anode_n), 32'h7);
    adv(8);  check("en_on_sel2", 32'(bus.digit_sel), 32'd2);
    adv(10); check("en_on_d2", 32'(bus.anode_n), 32'hB);

    // Asynchronous reset mid-slot
    start_scan();
    adv(11);
    #2 reset_n = 1'b0;
    #1;
    check("arst_an", 32'(bus.anode_n), 32'hF);
    check("arst_sel", 32'(bus.digit_sel), 32'd3);
    check("arst_dp", 32'(bus.dp_n), 32'd1);
    check("arst_fd", 32'(bus.frame_done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tt = 0;
    check("arst_restart_sel", 32'(bus.digit_sel), 32'd3);
    adv(2);  check("arst_d3", 32'(bus.anode_n), 32'h7);
    adv(10); check("arst_d2", 32'(bus.digit_sel), 32'd2);
    adv(40);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
